// File: rtl/memory_access_block.sv
// memory_access_block: execute-side ALU, NZCV flags, load/store steering and unified RAM.
// Optional feature macro ALU_MUL_EN: opcode D becomes a low-word multiply, else a NOP.
module memory_access_block #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              execute,
  input  logic [ADDR_W-1:0] pc,
  input  logic [3:0]        op_code,
  input  logic [3:0]        condition,
  input  logic              s_bit,
  input  logic [31:0]       source_1,
  input  logic [31:0]       source_2,
  input  logic [15:0]       immediate_value,
  output logic [31:0]       data_out,
  output logic [ADDR_W-1:0] address,
  output logic              read_write,
  output logic [31:0]       result,
  output logic [31:0]       ldr,
  output logic              ldr_we,
  output logic [3:0]        flags
);

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_ORR,
    OP_EOR, OP_LSL, OP_LSR, OP_ASR,
    OP_MOVI, OP_ADDI, OP_CMP, OP_LDR,
    OP_STR, OP_MUL, OP_MOV, OP_NOP
  } op_e;

  logic [31:0] Mem [0:2**ADDR_W-1];

  op_e         op;
  logic [3:0]  flags_q, flags_d;
  logic        n_q, z_q, c_q, v_q;
  logic [32:0] add_w, sub_w, addi_w;
  logic [15:0] ea;
  logic [4:0]  sh, sh_m1, lsl_idx;
  logic        c_d, v_d;
  logic        pass, live, flag_we;
  logic        is_ldr, is_str, is_cmp, mem_sel;

  assign op = op_e'(op_code);
  assign {n_q, z_q, c_q, v_q} = flags_q;

  assign add_w  = {1'b0, source_1} + {1'b0, source_2};
  assign sub_w  = {1'b0, source_1} - {1'b0, source_2};
  assign addi_w = {1'b0, source_1} + {17'h0, immediate_value};
  assign ea     = source_1[15:0] + immediate_value;

  // Shift carry: LSL drops bit 32-sh, right shifts drop bit sh-1.
  assign sh      = source_2[4:0];
  assign sh_m1   = sh - 5'd1;
  assign lsl_idx = 5'd0 - sh;

  always_comb begin
    result = 32'h0;
    c_d    = c_q;
    v_d    = v_q;
    case (op)
      OP_ADD: begin
        result = add_w[31:0];
        c_d    = add_w[32];
        v_d    = (source_1[31] == source_2[31])
               & (add_w[31] != source_1[31]);
      end
      OP_SUB, OP_CMP: begin
        result = sub_w[31:0];
        c_d    = ~sub_w[32];
        v_d    = (source_1[31] != source_2[31])
               & (sub_w[31] != source_1[31]);
      end
      OP_AND: result = source_1 & source_2;
      OP_ORR: result = source_1 | source_2;
      OP_EOR: result = source_1 ^ source_2;
      OP_LSL: begin
        result = source_1 << sh;
        if (sh != 5'd0) c_d = source_1[lsl_idx];
      end
      OP_LSR: begin
        result = source_1 >> sh;
        if (sh != 5'd0) c_d = source_1[sh_m1];
      end
      OP_ASR: begin
        result = $unsigned($signed(source_1) >>> sh);
        if (sh != 5'd0) c_d = source_1[sh_m1];
      end
      OP_MOVI: result = {16'h0, immediate_value};
      OP_ADDI: begin
        result = addi_w[31:0];
        c_d    = addi_w[32];
        v_d    = ~source_1[31] & addi_w[31];
      end
      OP_LDR, OP_STR: result = {16'h0, ea};
      OP_MUL: begin
`ifdef ALU_MUL_EN
        result = source_1 * source_2;
`else
        result = 32'h0;
`endif
      end
      OP_MOV:  result = source_2;
      default: result = 32'h0;
    endcase
  end

  always_comb begin
    pass = 1'b0;
    case (condition)
      4'h0: pass = z_q;
      4'h1: pass = ~z_q;
      4'h2: pass = c_q;
      4'h3: pass = ~c_q;
      4'h4: pass = n_q;
      4'h5: pass = ~n_q;
      4'h6: pass = v_q;
      4'h7: pass = ~v_q;
      4'h8: pass = c_q & ~z_q;
      4'h9: pass = ~c_q | z_q;
      4'hA: pass = (n_q == v_q);
      4'hB: pass = (n_q != v_q);
      4'hC: pass = ~z_q & (n_q == v_q);
      4'hD: pass = z_q | (n_q != v_q);
      4'hE: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

`ifdef ALU_MUL_EN
  assign live = (op != OP_NOP);
`else
  assign live = (op != OP_NOP) && (op != OP_MUL);
`endif

  assign is_ldr = (op == OP_LDR);
  assign is_str = (op == OP_STR);
  assign is_cmp = (op == OP_CMP);

  assign flags_d = {result[31], result == 32'h0, c_d, v_d};
  assign flag_we = execute & pass & live & (s_bit | is_cmp);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) flags_q <= 4'b0000;
    else if (flag_we) flags_q <= flags_d;
  end

  assign flags = flags_q;

  assign mem_sel = reset & execute & pass & (is_ldr | is_str);
  assign address = mem_sel ? result[ADDR_W-1:0] : pc;

  assign read_write = enable & reset & execute & pass & is_str;
  assign data_out   = enable ? Mem[address] : 32'h0;

  // RAM has no reset: contents survive reset and may be preloaded.
  always_ff @(posedge clk) begin
    if (read_write) Mem[address] <= source_2;
  end

  assign ldr_we = execute & pass & reset & live & ~is_cmp & ~is_str;
  assign ldr    = (ldr_we & is_ldr) ? data_out : result;

endmodule

// File: tb/tb_memory_access_block.sv
// tb_memory_access_block: directed cases plus random instructions checked
// against an arithmetic reference model with a sparse memory image.
module tb_memory_access_block;

`ifdef ALU_MUL_EN
  localparam bit MUL_ON = 1'b1;
`else
  localparam bit MUL_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, enable, execute, s_bit;
  logic [15:0] pc, immediate_value, address;
  logic [3:0]  op_code, condition, flags;
  logic [31:0] source_1, source_2, data_out, result, ldr;
  logic        read_write, ldr_we;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0]  fl_m;
  logic [31:0] mem_m [int];

  always #5 clk = ~clk;

  memory_access_block #(.ADDR_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .execute(execute), .pc(pc), .op_code(op_code),
    .condition(condition), .s_bit(s_bit),
    .source_1(source_1), .source_2(source_2),
    .immediate_value(immediate_value),
    .data_out(data_out), .address(address),
    .read_write(read_write), .result(result),
    .ldr(ldr), .ldr_we(ldr_we), .flags(flags)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit cond_ok(input logic [3:0] c,
                                 input logic [3:0] f);
    bit n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Reference ALU: wide signed/unsigned arithmetic, 64-bit shifts.
  function automatic void alu_m(
    input  logic [3:0]  op,
    input  logic [31:0] a, b,
    input  logic [15:0] im,
    output logic [31:0] r,
    output bit cset, output bit c,
    output bit vset, output bit v);
    longint unsigned u;
    longint s;
    int sh;
    sh = int'(b[4:0]);
    cset = 0; vset = 0; c = 0; v = 0;
    case (op)
      4'h0, 4'h9: begin
        logic [31:0] bb;
        bb = (op == 4'h0) ? b : {16'h0, im};
        u = {32'h0, a} + {32'h0, bb};
        s = longint'($signed(a)) + longint'($signed(bb));
        r = u[31:0];
        cset = 1; c = u[32];
        vset = 1; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'h1, 4'hA: begin
        s = longint'($signed(a)) - longint'($signed(b));
        r = a - b;
        cset = 1; c = (a >= b);
        vset = 1; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: begin
        u = {32'h0, a} << sh;
        r = u[31:0];
        cset = (sh != 0); c = u[32];
      end
      4'h6: begin
        u = {a, 32'h0} >> sh;
        r = u[63:32];
        cset = (sh != 0); c = u[31];
      end
      4'h7: begin
        s = {a, 32'h0};
        s = s >>> sh;
        r = s[63:32];
        cset = (sh != 0); c = s[31];
      end
      4'h8: r = {16'h0, im};
      4'hB, 4'hC: r = (32'(a[15:0]) + 32'(im)) & 32'h0000FFFF;
      4'hD: r = MUL_ON ? a * b : 32'h0;
      4'hE: r = b;
      default: r = 32'h0;
    endcase
  endfunction

  task automatic step(input logic [3:0] op, cnd,
                      input logic sb,
                      input logic [31:0] a, b,
                      input logic [15:0] im,
                      input logic en, ex);
    logic [31:0] r, d_exp;
    bit cs, c, vs, v, ps, live, msel, rw_e, we_e, known;
    logic [15:0] a_exp;
    @(negedge clk);
    op_code = op; condition = cnd; s_bit = sb;
    source_1 = a; source_2 = b; immediate_value = im;
    enable = en; execute = ex;
    pc = 16'($urandom_range(0, 63));
    #1;
    alu_m(op, a, b, im, r, cs, c, vs, v);
    ps    = cond_ok(cnd, fl_m);
    live  = (op != 4'hF) && (op != 4'hD || MUL_ON);
    msel  = ex && ps && (op == 4'hB || op == 4'hC);
    a_exp = msel ? r[15:0] : pc;
    rw_e  = en && ex && ps && (op == 4'hC);
    we_e  = ex && ps && live && op != 4'hA && op != 4'hC;
    known = !en || mem_m.exists(int'(a_exp));
    d_exp = !en ? 32'h0 : (known ? mem_m[int'(a_exp)] : 32'h0);
    chk("result", result, r);
    chk("address", 32'(address), 32'(a_exp));
    chk("read_write", 32'(read_write), 32'(rw_e));
    chk("ldr_we", 32'(ldr_we), 32'(we_e));
    if (known) chk("data_out", data_out, d_exp);
    if (!(we_e && op == 4'hB)) chk("ldr", ldr, r);
    else if (known) chk("ldr_load", ldr, d_exp);
    @(posedge clk);
    if (rw_e) mem_m[int'(a_exp)] = b;
    if (ex && ps && live && (sb || op == 4'hA))
      fl_m = {r[31], r == 32'h0,
              cs ? c : fl_m[1], vs ? v : fl_m[0]};
    #1;
    chk("flags", 32'(flags), 32'(fl_m));
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; execute = 1'b0;
    s_bit = 1'b0; pc = 16'h0; op_code = 4'hF;
    condition = 4'hE; source_1 = 0; source_2 = 0;
    immediate_value = 0;
    fl_m = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flags", 32'(flags), 32'h0);
    chk("rst_rw", 32'(read_write), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    step(4'h0, 4'hE, 1, 32'hFFFFFFFF, 32'h1, 16'h0, 1, 1);
    chk("add_zc", 32'(flags), 32'h6);
    step(4'hA, 4'hE, 0, 32'd5, 32'd7, 16'h0, 1, 1);
    chk("cmp_n", 32'(flags), 32'h8);
    step(4'h0, 4'hB, 0, 32'd1, 32'd2, 16'h0, 1, 1);
    step(4'h0, 4'hA, 0, 32'd1, 32'd2, 16'h0, 1, 1);
    step(4'hC, 4'hE, 0, 32'h10, 32'hDEADBEEF, 16'd4, 1, 1);
    chk("mem20", dut.Mem[20], 32'hDEADBEEF);
    step(4'hB, 4'hE, 0, 32'h10, 32'h0, 16'd4, 1, 1);
    chk("ldr20", ldr, 32'hDEADBEEF);
    step(4'hC, 4'hE, 0, 32'h10, 32'h01234567, 16'd4, 0, 1);
    chk("str_dis", dut.Mem[20], 32'hDEADBEEF);
    step(4'h5, 4'hE, 1, 32'h80000001, 32'd1, 16'h0, 1, 1);
    chk("lsl_c", 32'(flags[1]), 32'h1);
    step(4'hD, 4'hE, 0, 32'd3, 32'd4, 16'h0, 1, 1);
    step(4'hA, 4'hE, 0, 32'd5, 32'd7, 16'h0, 1, 1);

    // Reset mid-cycle over a pending store.
    @(negedge clk);
    op_code = 4'hC; condition = 4'hE; execute = 1'b1;
    enable = 1'b1; source_1 = 32'h10; immediate_value = 16'd4;
    source_2 = 32'h12345678; pc = 16'd33;
    reset = 1'b0;
    #1;
    fl_m = 4'b0000;
    chk("arst_flags", 32'(flags), 32'h0);
    chk("arst_rw", 32'(read_write), 32'h0);
    chk("arst_addr", 32'(address), 32'd33);
    chk("arst_we", 32'(ldr_we), 32'h0);
    @(posedge clk); #1;
    chk("arst_mem", dut.Mem[20], mem_m[20]);
    @(negedge clk);
    reset = 1'b1; execute = 1'b0; pc = 16'd7;
    #1;
    chk("rel_addr", 32'(address), 32'd7);
    chk("rel_rw", 32'(read_write), 32'h0);

    for (int i = 0; i < 400; i++) begin
      logic [3:0]  op, cnd;
      logic [31:0] a, b;
      logic [15:0] im;
      op  = 4'($urandom_range(0, 15));
      cnd = ($urandom_range(0, 1) == 0) ? 4'hE
          : 4'($urandom_range(0, 15));
      a   = $urandom;
      b   = $urandom;
      im  = 16'($urandom);
      if (op == 4'hB || op == 4'hC) begin
        a[15:0] = 16'($urandom_range(0, 31));
        im = 16'($urandom_range(0, 31));
      end
      if ($urandom_range(0, 7) == 0) b = a;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 3));
      step(op, cnd, 1'($urandom), a, b, im,
           $urandom_range(0, 7) != 0,
           $urandom_range(0, 9) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
